// File: rtl/rvfi_channel_serializer_if.sv
// rvfi_channel_serializer_if: multi-retire input bus and single-channel output bus
interface rvfi_channel_serializer_if #(
    parameter int NRET    = 2,
    parameter int ORDER_W = 64,
    parameter int PKT_W   = 256,
    parameter int DEPTH   = 8
);
    logic [NRET-1:0]           rvfi_valid;
    logic [NRET*ORDER_W-1:0]   rvfi_order;
    logic [NRET*PKT_W-1:0]     rvfi_pkt;
    logic                      out_valid;
    logic                      out_ready;
    logic [ORDER_W-1:0]        out_order;
    logic [PKT_W-1:0]          out_pkt;
    logic [$clog2(DEPTH):0]    out_count;
    logic                      overflow;
    logic                      order_err;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_pkt, out_ready,
        input  out_valid, out_order, out_pkt, out_count, overflow, order_err
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_pkt, out_ready,
        output out_valid, out_order, out_pkt, out_count, overflow, order_err
    );
endinterface

// File: rtl/rvfi_channel_serializer.sv
// rvfi_channel_serializer: buffers NRET retirements/cycle, emits one per cycle; RISCV_FORMAL_SERIALIZER_ASSERT_EN adds assertions
module rvfi_channel_serializer #(
    parameter int NRET    = 2,
    parameter int ORDER_W = 64,
    parameter int PKT_W   = 256,
    parameter int DEPTH   = 8
) (
    input logic                   clock,
    input logic                   reset,
    rvfi_channel_serializer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ORDER_W-1:0] order_mem_q [DEPTH];
    logic [ORDER_W-1:0] order_mem_d [DEPTH];
    logic [PKT_W-1:0]   pkt_mem_q   [DEPTH];
    logic [PKT_W-1:0]   pkt_mem_d   [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d, n_acc, free;
    logic               overflow_q, overflow_d, order_err_q, order_err_d;
    logic               first_seen_q, first_seen_d, pop;
    logic [ORDER_W-1:0] expected_order_q, expected_order_d, ord;
    logic [ORDER_W-1:0] out_order_q, out_order_d;
    logic [PKT_W-1:0]   out_pkt_q, out_pkt_d;

    // compact valid channels into the FIFO, check order continuity, and look ahead to the next head
    always_comb begin
        pop              = (count_q != '0) && bus.out_ready;
        order_mem_d      = order_mem_q;
        pkt_mem_d        = pkt_mem_q;
        overflow_d       = overflow_q;
        order_err_d      = order_err_q;
        first_seen_d     = first_seen_q;
        expected_order_d = expected_order_q;
        ord              = '0;
        n_acc            = '0;
        free             = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
        for (int c = 0; c < NRET; c++) begin
            ord = bus.rvfi_order[c*ORDER_W +: ORDER_W];
            if (bus.rvfi_valid[c] && n_acc < free) begin
                order_mem_d[tail_q + n_acc[PTR_W-1:0]] = ord;
                pkt_mem_d[tail_q + n_acc[PTR_W-1:0]]   = bus.rvfi_pkt[c*PKT_W +: PKT_W];
                order_err_d      = order_err_d | (first_seen_d && ord != expected_order_d);
                first_seen_d     = 1'b1;
                expected_order_d = ord + ORDER_W'(1);
                n_acc            = n_acc + CNT_W'(1);
            end else if (bus.rvfi_valid[c]) begin
                overflow_d = 1'b1;
            end
        end
        head_d      = head_q + PTR_W'(pop);
        tail_d      = tail_q + n_acc[PTR_W-1:0];
        count_d     = count_q - CNT_W'(pop) + n_acc;
        out_order_d = (count_d != '0) ? order_mem_d[head_d] : out_order_q;
        out_pkt_d   = (count_d != '0) ? pkt_mem_d[head_d] : out_pkt_q;
    end

    // payload storage needs no reset: occupancy decides what is live
    always_ff @(posedge clock) begin
        order_mem_q <= order_mem_d;
        pkt_mem_q   <= pkt_mem_d;
    end

    // control state and registered head outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            order_err_q      <= 1'b0;
            first_seen_q     <= 1'b0;
            expected_order_q <= '0;
            out_order_q      <= '0;
            out_pkt_q        <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            order_err_q      <= order_err_d;
            first_seen_q     <= first_seen_d;
            expected_order_q <= expected_order_d;
            out_order_q      <= out_order_d;
            out_pkt_q        <= out_pkt_d;
        end
    end

    assign bus.out_valid = count_q != '0;
    assign bus.out_count = count_q;
    assign bus.out_order = out_order_q;
    assign bus.out_pkt   = out_pkt_q;
    assign bus.overflow  = overflow_q;
    assign bus.order_err = order_err_q;

`ifdef RISCV_FORMAL_SERIALIZER_ASSERT_EN
    // status must stay clean and a stalled head must never vanish
    always @(posedge clock) begin
        if (!reset) begin
            assert (!overflow_q);
            assert (!order_err_q);
            assert (!(count_q != '0 && !bus.out_ready && count_d == '0));
        end
    end
`else
`endif
endmodule

// File: doc/rvfi_channel_serializer.md
Name: rvfi_channel_serializer

Overview:
- Sits between a multi-retire core's RVFI outputs and a single-channel instruction checker.
- Captures up to NRET retirements per cycle and buffers them in a FIFO.
- Emits one retirement per cycle, in ascending rvfi_order, as a single-channel packet.
- Also checks order continuity and flags buffer overflow so a dropped or duplicated retirement cannot hide from the downstream check.

Parameters:
- NRET, 2, number of retire channels on the input side.
- ORDER_W, 64, width of rvfi_order per channel.
- PKT_W, 256, width of the opaque per-channel payload (remaining RVFI fields, concatenated by the wrapper).
- DEPTH, 8, FIFO entries; power of two; at least 2*NRET.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- rvfi_valid  in  NRET  per-channel retire valid
- rvfi_order  in  NRET*ORDER_W  per-channel order; channel c at [c*ORDER_W +: ORDER_W]
- rvfi_pkt  in  NRET*PKT_W  per-channel payload; channel c at [c*PKT_W +: PKT_W]
- out_valid  out  1  head entry present
- out_ready  in  1  consumer takes the head this cycle
- out_order  out  ORDER_W  order of the head entry
- out_pkt  out  PKT_W  payload of the head entry
- out_count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; one or more retirements were dropped
- order_err  out  1  sticky; order discontinuity detected

Behaviour:
- Reset (synchronous, active-high, sampled at the clock edge):
  - head, tail and count go to 0.
  - out_valid=0, out_count=0, overflow=0, order_err=0.
  - first_seen cleared; expected_order=0.
  - out_order and out_pkt read 0.
  - Asserting reset mid-operation flushes all entries and discards any same-cycle inputs.
- Push: every cycle, valid channels are compacted in ascending channel index and written at tail, tail+1, and so on. Gaps between valid channels are legal (e.g. valid=2'b10 pushes one entry, channel 1).
- Pop: when out_valid && out_ready, head advances by 1. Pointers wrap modulo DEPTH.
- Occupancy: count_next = count - pop + accepted pushes.
  - Pop and push in the same cycle are legal, including at full: the popped slot is reusable that cycle.
- Overflow: if count - pop + n_valid > DEPTH, only the lowest-index valid channels that fit are accepted. The rest are dropped and overflow sets, staying set until reset.
- Output (first-word fall-through, registered):
  - out_valid = (count != 0).
  - out_order and out_pkt are the head entry.
  - A push at cycle t appears on the outputs at t+1, never combinationally.
  - When empty, out_order and out_pkt hold their last value; consumers must qualify them with out_valid.
- Order check (applies to every accepted entry, in compaction order):
  - The first accepted entry after reset sets expected_order = its order + 1 and sets first_seen; no check is made on it.
  - Each later entry compares its order to expected_order. On mismatch, order_err sets (sticky).
  - expected_order always advances to entry order + 1, so one fault reports once and is not repeated for every later entry.
  - Multiple entries in one cycle are checked sequentially within that cycle.
  - Dropped entries are not checked and do not advance expected_order.
- Arithmetic: order compare and increment are ORDER_W-bit; wrap from all-ones to 0 counts as continuous.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: RISCV_FORMAL_SERIALIZER_ASSERT_EN
- Defined: immediate assertions `assert(!overflow)` and `assert(!order_err)` are evaluated every cycle while reset is low. An additional assertion requires that out_valid never falls while out_ready=0 and no reset occurs.
- Undefined: no assertions are compiled; overflow and order_err are reported as sticky status only.

Test Plan:
- Reset with valid=2'b11, orders 0/1 on the reset cycle → nothing stored; out_valid=0, out_count=0 the next cycle.
- Cycle 1: valid=2'b11, orders 5/6; out_ready=1 → cycle 2 out_order=5; cycle 3 out_order=6; cycle 4 out_valid=0; order_err=0.
- valid=2'b10 with order 7, after orders 5/6 above → single entry at out_order=7; no order_err.
- out_ready=0; push 2 entries per cycle for 4 cycles (orders 0–7) → out_count=8; a fifth cycle with both valid sets overflow, and count stays 8. Repeat at count=8 with out_ready=1 and valid=2'b01 → accepted, count stays 8, no overflow.
- Orders 10, 11, then 13 → order_err sets on the cycle 13 is pushed and holds. A following 14 does not re-fault; reset clears the flag.
- Fill mid-stream to count=3, then assert reset for one cycle → out_valid=0, flags clear. A first push of order 100 is accepted with no error.
